// File: rtl/serial_add_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_add_cell.sv
// 1-bit full adder with a carry flop; init loads the carry synchronously and wins over en.
module serial_add_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic init,
    input  logic init_val,
    input  logic en,
    output logic s,
    output logic carry_next
);

    logic carry_q;

    assign s          = a ^ b ^ carry_q;
    assign carry_next = (a & b) | (a & carry_q) | (b & carry_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (init) begin
            carry_q <= init_val;
        end else if (en) begin
            carry_q <= carry_next;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: LSB-first, one bit per clock, done pulse after WIDTH bits.
// Define SERIAL_ADD_SUB_EN to add the sub port (A - B via inverted B and carry-in of 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cout_q;
    logic             accept, shifting, last_bit;
    logic             bit_s, carry_next;
    logic [WIDTH-1:0] b_cap;
    logic             carry_init;

    assign accept   = (state_q == ST_IDLE) && start;
    assign shifting = (state_q == ST_SHIFT);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: A + ~B + 1, so cout=1 means no borrow.
    assign b_cap      = sub ? ~b_in : b_in;
    assign carry_init = sub;
`else
    assign b_cap      = b_in;
    assign carry_init = 1'b0;
`endif

    serial_add_cell u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a_q[0]),
        .b          (b_q[0]),
        .init       (accept),
        .init_val   (carry_init),
        .en         (shifting),
        .s          (bit_s),
        .carry_next (carry_next)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a_in;
                b_q   <= b_cap;
                cnt_q <= '0;
            end else if (shifting) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                sum_q <= {bit_s, sum_q[WIDTH-1:1]};
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cout_q <= carry_next;
                end
            end
        end
    end

    assign ready = (state_q == ST_IDLE);
    assign busy  = shifting;
    assign done  = (state_q == ST_DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       ready, busy, done, cout;
    logic [7:0] sum;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a_in  (a_in),
        .b_in  (b_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // One start pulse; returns negedges until done is seen (0 on timeout) and the result.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [7:0] s, output logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        lat   = 0;
        s     = 'x;
        c     = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                s   = sum;
                c   = cout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    endtask

    task automatic test_basic();
        int lat; logic [7:0] s; logic c;
        run_op(8'h35, 8'h4A, lat, s, c);
        checks++; if (lat !== 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (s !== 8'h7F) begin failures++; $display("FAIL basic_sum got=%h exp=7f", s); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", c); end
        @(negedge clk);
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL basic_ready_after got=%b%b exp=10", ready, done); end
        repeat (2) @(negedge clk);
        checks++; if (sum !== 8'h7F) begin failures++; $display("FAIL basic_sum_hold got=%h exp=7f", sum); end
    endtask

    task automatic test_carry();
        int lat; logic [7:0] s; logic c;
        run_op(8'hFF, 8'h01, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'h00 || c !== 1'b1) begin
            failures++; $display("FAIL carry_ff01 got=%0d/%h/%b exp=9/00/1", lat, s, c); end
        run_op(8'h80, 8'h80, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'h00 || c !== 1'b1) begin
            failures++; $display("FAIL carry_8080 got=%0d/%h/%b exp=9/00/1", lat, s, c); end
        run_op(8'h01, 8'h01, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'h02 || c !== 1'b0) begin
            failures++; $display("FAIL carry_noleak got=%0d/%h/%b exp=9/02/0", lat, s, c); end
    endtask

    task automatic test_held_start();
        int n_done = 0;
        int expect_at;
        @(negedge clk);
        a_in  = 8'h01;
        b_in  = 8'h02;
        start = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                expect_at = 10 * n_done - 1;
                checks++; if (i !== expect_at || sum !== 8'h03) begin
                    failures++;
                    $display("FAIL held_pulse got=t%0d/%h exp=t%0d/03", i, sum, expect_at);
                end
            end
        end
        checks++; if (n_done !== 3) begin failures++; $display("FAIL held_count got=%0d exp=3", n_done); end
        start = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int lat; logic [7:0] s; logic c;
        @(negedge clk);
        a_in  = 8'h35;
        b_in  = 8'h4A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state got=%b%b/%h/%b exp=10/00/0", ready, busy, sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL midreset_nodone got=%0d exp=0", n_done); end
        run_op(8'h10, 8'h20, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'h30 || c !== 1'b0) begin
            failures++; $display("FAIL midreset_next got=%0d/%h/%b exp=9/30/0", lat, s, c); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int n_done = 0;
        logic [7:0] s = 'x;
        @(negedge clk);
        a_in  = 8'h0F;
        b_in  = 8'h01;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 1) begin
                a_in = 8'hAA;
                b_in = 8'h55;
            end
            if (done && lat == 0) begin
                lat = i;
                s   = sum;
            end else if (done) begin
                n_done++;
            end
        end
        checks++; if (lat !== 9 || s !== 8'h10) begin
            failures++; $display("FAIL b2b_sum got=%0d/%h exp=9/10", lat, s); end
        checks++; if (n_done !== 0) begin failures++; $display("FAIL b2b_noqueue got=%0d exp=0", n_done); end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat; logic [7:0] s; logic c;
        sub = 1'b1;
        run_op(8'h10, 8'h01, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'h0F || c !== 1'b1) begin
            failures++; $display("FAIL sub_nob got=%0d/%h/%b exp=9/0f/1", lat, s, c); end
        run_op(8'h01, 8'h02, lat, s, c);
        checks++; if (lat !== 9 || s !== 8'hFF || c !== 1'b0) begin
            failures++; $display("FAIL sub_borrow got=%0d/%h/%b exp=9/ff/0", lat, s, c); end
        sub = 1'b0;
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_carry();
        test_held_start();
        test_reset_mid();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
